// File: rtl/ir_level_ctrl.sv
// ir_level_ctrl: turns validated IR remote codes into per-channel intensity
// levels for a bank of PWM generators. It checks the address and the command
// complement, applies saturating coarse/fine steps, and supports broadcast
// commands. An optional fade mode ramps each level toward its target.
//
// Handshake: new_code_in is a valid-only strobe with no ready. code_in is
// sampled only in a cycle where new_code_in=1. Every strobe is consumed at
// the next rising edge, so strobes may arrive in back-to-back cycles.
module ir_level_ctrl #(
    parameter int          NUM_CH      = 3,
    parameter int          WIDTH       = 8,
    parameter int          COARSE_STEP = 5,
    parameter int          FINE_STEP   = 1,
    parameter int          RESET_LEVEL = 1,
    parameter logic [15:0] ADDR        = 16'h57E3,
    parameter logic [7:0]  CMD_BASE    = 8'h10,
    parameter logic [7:0]  CMD_ALL_OFF = 8'h40,
    parameter logic [7:0]  CMD_RESTORE = 8'h41,
    parameter logic [7:0]  CMD_MODE    = 8'h42,
    parameter int          RAMP_DIV    = 100000
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic [31:0]             code_in,
    input  logic                    new_code_in,
    output logic [NUM_CH*WIDTH-1:0] level_out,
    output logic [NUM_CH*WIDTH-1:0] target_out,
    output logic                    fade_mode_out,
    output logic                    busy_out,
    output logic                    cmd_ok_out,
    output logic                    err_out,
    output logic [1:0]              err_code_out
);

    localparam int               PW        = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [PW-1:0]    PRESC_MAX = PW'(RAMP_DIV - 1);
    localparam logic [WIDTH:0]   COARSE_W  = (WIDTH+1)'(COARSE_STEP);
    localparam logic [WIDTH:0]   FINE_W    = (WIDTH+1)'(FINE_STEP);
    localparam logic [WIDTH-1:0] RST_LVL   = WIDTH'(RESET_LEVEL);
    localparam logic [WIDTH-1:0] MAX_LVL   = '1;
    localparam logic [8:0]       CH_SPAN   = 9'(4 * NUM_CH);

    // Sums and differences are formed one bit wider so the carry/borrow
    // flags the overflow; the result clamps instead of wrapping.
    function automatic logic [WIDTH-1:0] sat_add(input logic [WIDTH-1:0] v,
                                                 input logic [WIDTH:0]   s);
        logic [WIDTH:0] r;
        r = {1'b0, v} + s;
        return r[WIDTH] ? MAX_LVL : r[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] sat_sub(input logic [WIDTH-1:0] v,
                                                 input logic [WIDTH:0]   s);
        logic [WIDTH:0] r;
        r = {1'b0, v} - s;
        return r[WIDTH] ? '0 : r[WIDTH-1:0];
    endfunction

    logic [WIDTH-1:0] target_q [NUM_CH];
    logic [WIDTH-1:0] target_d [NUM_CH];
    logic [WIDTH-1:0] level_q  [NUM_CH];
    logic [WIDTH-1:0] level_d  [NUM_CH];
    logic [PW-1:0]    presc_q, presc_d;
    logic             fade_q, fade_d;
    logic             busy_q, busy_d;
    logic             cmd_ok_q, cmd_ok_d;
    logic             err_q, err_d;
    logic [1:0]       err_code_q, err_code_d;

    logic [7:0] cmd, inv;
    logic       addr_ok, inv_ok, ch_hit, special, accept, tick;
    logic [8:0] idx_w;
    logic [5:0] ch_sel;
    logic [1:0] op;

    // Field split and validity checks of the incoming code.
    always_comb begin
        cmd     = code_in[15:8];
        inv     = code_in[7:0];
        addr_ok = (code_in[31:16] == ADDR);
        inv_ok  = (inv == ~cmd);
        idx_w   = {1'b0, cmd} - {1'b0, CMD_BASE};
        // Bit 8 is the borrow: set when cmd lies below CMD_BASE.
        ch_hit  = !idx_w[8] && (idx_w < CH_SPAN);
        ch_sel  = idx_w[7:2];
        op      = idx_w[1:0];
        special = (cmd == CMD_ALL_OFF) || (cmd == CMD_RESTORE) || (cmd == CMD_MODE);
        accept  = new_code_in && addr_ok && inv_ok && (ch_hit || special);
        tick    = (presc_q == PRESC_MAX);
    end

    // Command execution: target updates, mode toggle, accept/reject pulses.
    always_comb begin
        target_d   = target_q;
        fade_d     = fade_q;
        cmd_ok_d   = 1'b0;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        if (accept) begin
            cmd_ok_d = 1'b1;
            if (ch_hit) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    if (int'(ch_sel) == k) begin
                        case (op)
                            2'd0:    target_d[k] = sat_add(target_q[k], COARSE_W);
                            2'd1:    target_d[k] = sat_sub(target_q[k], COARSE_W);
                            2'd2:    target_d[k] = sat_add(target_q[k], FINE_W);
                            default: target_d[k] = sat_sub(target_q[k], FINE_W);
                        endcase
                    end
                end
            end else if (cmd == CMD_ALL_OFF) begin
                for (int k = 0; k < NUM_CH; k++) target_d[k] = '0;
            end else if (cmd == CMD_RESTORE) begin
                for (int k = 0; k < NUM_CH; k++) target_d[k] = RST_LVL;
            end else begin
                fade_d = !fade_q;
            end
        end else if (new_code_in) begin
            err_d = 1'b1;
            if (!addr_ok)     err_code_d = 2'd1;
            else if (!inv_ok) err_code_d = 2'd2;
            else              err_code_d = 2'd3;
        end
    end

    // Level tracking: snap copies the new target, fade steps toward the
    // pre-command target on a prescaler tick; busy mirrors the next state.
    always_comb begin
        level_d = level_q;
        busy_d  = 1'b0;
        presc_d = tick ? '0 : presc_q + 1'b1;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!fade_d) begin
                level_d[k] = target_d[k];
            end else if (tick && (level_q[k] != target_q[k])) begin
                level_d[k] = (level_q[k] < target_q[k]) ? level_q[k] + 1'b1
                                                         : level_q[k] - 1'b1;
            end
            busy_d = busy_d | (level_d[k] != target_d[k]);
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int k = 0; k < NUM_CH; k++) begin
                target_q[k] <= RST_LVL;
                level_q[k]  <= RST_LVL;
            end
            presc_q    <= '0;
            fade_q     <= 1'b0;
            busy_q     <= 1'b0;
            cmd_ok_q   <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'd0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                target_q[k] <= target_d[k];
                level_q[k]  <= level_d[k];
            end
            presc_q    <= presc_d;
            fade_q     <= fade_d;
            busy_q     <= busy_d;
            cmd_ok_q   <= cmd_ok_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    // Pack per-channel registers onto the output buses.
    always_comb begin
        level_out  = '0;
        target_out = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            level_out[k*WIDTH +: WIDTH]  = level_q[k];
            target_out[k*WIDTH +: WIDTH] = target_q[k];
        end
    end

    assign fade_mode_out = fade_q;
    assign busy_out      = busy_q;
    assign cmd_ok_out    = cmd_ok_q;
    assign err_out       = err_q;
    assign err_code_out  = err_code_q;

endmodule

// File: tb/tb_ir_level_ctrl.sv
// Directed testbench for ir_level_ctrl (3 channels x 8 bits, RAMP_DIV = 4).
module tb_ir_level_ctrl;

  localparam int NUM_CH = 3;
  localparam int WIDTH  = 8;
  localparam int LW     = NUM_CH * WIDTH;

  localparam logic [31:0] C_UP0     = 32'h57E310EF; // ch0 coarse up
  localparam logic [31:0] C_FDN1    = 32'h57E317E8; // ch1 fine down
  localparam logic [31:0] C_FUP0    = 32'h57E312ED; // ch0 fine up
  localparam logic [31:0] C_UP1     = 32'h57E314EB; // ch1 coarse up
  localparam logic [31:0] C_ALL_OFF = 32'h57E340BF;
  localparam logic [31:0] C_MODE    = 32'h57E342BD;
  localparam logic [31:0] C_BADADR  = 32'h12E310EF;
  localparam logic [31:0] C_BADINV  = 32'h57E310EE;
  localparam logic [31:0] C_BADCMD  = 32'h57E37F80;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   code;
  logic          new_code;
  logic [LW-1:0] level_out, target_out;
  logic          fade_mode_out, busy_out, cmd_ok_out, err_out;
  logic [1:0]    err_code_out;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ir_level_ctrl #(
    .NUM_CH   (NUM_CH),
    .WIDTH    (WIDTH),
    .RAMP_DIV (4)
  ) dut (
    .clk_in        (clk),
    .rst_n_in      (rst_n),
    .code_in       (code),
    .new_code_in   (new_code),
    .level_out     (level_out),
    .target_out    (target_out),
    .fade_mode_out (fade_mode_out),
    .busy_out      (busy_out),
    .cmd_ok_out    (cmd_ok_out),
    .err_out       (err_out),
    .err_code_out  (err_code_out)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  // All tasks start and end at a falling edge.
  task automatic apply_reset();
    rst_n    = 1'b0;
    new_code = 1'b0;
    code     = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One-cycle strobe; returns after the consuming edge so outputs are settled.
  task automatic send(input logic [31:0] c);
    code     = c;
    new_code = 1'b1;
    @(negedge clk);
    new_code = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n    = 1'b0;
    new_code = 1'b0;
    code     = '0;
    @(negedge clk);
    vectors++;
    if (level_out !== 24'h010101) begin
      miscompares++;
      $display("FAIL reset_level: got %h expected %h", level_out, 24'h010101);
    end
    vectors++;
    if (target_out !== 24'h010101) begin
      miscompares++;
      $display("FAIL reset_target: got %h expected %h", target_out, 24'h010101);
    end
    vectors++;
    if ({fade_mode_out, busy_out, cmd_ok_out, err_out, err_code_out} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got %b expected 000000",
               {fade_mode_out, busy_out, cmd_ok_out, err_out, err_code_out});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_coarse_saturate();
    int exp;
    apply_reset();
    for (int i = 0; i < 51; i++) begin
      send(C_UP0);
      exp = 1 + 5 * (i + 1);
      if (exp > 255) exp = 255;
      vectors++;
      if (level_out[7:0] !== 8'(exp)) begin
        miscompares++;
        $display("FAIL coarse_step%0d: got %0d expected %0d", i, level_out[7:0], exp);
      end
      vectors++;
      if (cmd_ok_out !== 1'b1 || err_out !== 1'b0) begin
        miscompares++;
        $display("FAIL coarse_ok%0d: got ok=%b err=%b expected ok=1 err=0", i, cmd_ok_out, err_out);
      end
    end
    vectors++;
    if (level_out[23:8] !== 16'h0101 || busy_out !== 1'b0) begin
      miscompares++;
      $display("FAIL coarse_others: got %h busy=%b expected 0101 busy=0", level_out[23:8], busy_out);
    end
    @(negedge clk);
    vectors++;
    if (cmd_ok_out !== 1'b0) begin
      miscompares++;
      $display("FAIL coarse_pulse_end: got %b expected 0", cmd_ok_out);
    end
  endtask

  task automatic test_fine_floor();
    apply_reset();
    for (int i = 0; i < 2; i++) begin
      send(C_FDN1);
      vectors++;
      if (level_out[15:8] !== 8'd0 || target_out[15:8] !== 8'd0) begin
        miscompares++;
        $display("FAIL fine_floor%0d: got lvl=%0d tgt=%0d expected 0", i, level_out[15:8], target_out[15:8]);
      end
      vectors++;
      if (cmd_ok_out !== 1'b1 || err_out !== 1'b0) begin
        miscompares++;
        $display("FAIL fine_floor_ok%0d: got ok=%b err=%b expected ok=1 err=0", i, cmd_ok_out, err_out);
      end
    end
  endtask

  task automatic test_errors();
    logic [31:0] codes [3];
    logic [1:0]  exp_ec [3];
    codes[0] = C_BADADR; exp_ec[0] = 2'd1;
    codes[1] = C_BADINV; exp_ec[1] = 2'd2;
    codes[2] = C_BADCMD; exp_ec[2] = 2'd3;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      send(codes[i]);
      vectors++;
      if (err_out !== 1'b1 || cmd_ok_out !== 1'b0 || err_code_out !== exp_ec[i]) begin
        miscompares++;
        $display("FAIL err%0d: got err=%b ok=%b code=%0d expected err=1 ok=0 code=%0d",
                 i, err_out, cmd_ok_out, err_code_out, exp_ec[i]);
      end
      vectors++;
      if (level_out !== 24'h010101 || target_out !== 24'h010101) begin
        miscompares++;
        $display("FAIL err_nochange%0d: got lvl=%h tgt=%h expected 010101", i, level_out, target_out);
      end
    end
    send(C_UP0);
    vectors++;
    if (err_out !== 1'b0 || cmd_ok_out !== 1'b1 || err_code_out !== 2'd3 || level_out[7:0] !== 8'd6) begin
      miscompares++;
      $display("FAIL err_hold: got err=%b ok=%b code=%0d lvl=%0d expected err=0 ok=1 code=3 lvl=6",
               err_out, cmd_ok_out, err_code_out, level_out[7:0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] codes [5];
    logic [23:0] exp_lvl [5];
    logic        exp_ok [5];
    codes[0] = C_UP0;    exp_lvl[0] = 24'h010106; exp_ok[0] = 1'b1;
    codes[1] = C_UP0;    exp_lvl[1] = 24'h01010B; exp_ok[1] = 1'b1;
    codes[2] = C_FUP0;   exp_lvl[2] = 24'h01010C; exp_ok[2] = 1'b1;
    codes[3] = C_BADADR; exp_lvl[3] = 24'h01010C; exp_ok[3] = 1'b0;
    codes[4] = C_UP1;    exp_lvl[4] = 24'h01060C; exp_ok[4] = 1'b1;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      send(codes[i]);
      vectors++;
      if (level_out !== exp_lvl[i] || cmd_ok_out !== exp_ok[i] || err_out !== !exp_ok[i]) begin
        miscompares++;
        $display("FAIL b2b%0d: got lvl=%h ok=%b err=%b expected lvl=%h ok=%b err=%b",
                 i, level_out, cmd_ok_out, err_out, exp_lvl[i], exp_ok[i], !exp_ok[i]);
      end
    end
  endtask

  task automatic test_fade_ramp();
    logic [7:0] prev, cur, exp_tgt;
    int last;
    bit done;
    apply_reset();
    send(C_MODE);
    vectors++;
    if (fade_mode_out !== 1'b1 || level_out !== 24'h010101 || busy_out !== 1'b0) begin
      miscompares++;
      $display("FAIL fade_on: got mode=%b lvl=%h busy=%b expected 1 010101 0", fade_mode_out, level_out, busy_out);
    end
    prev = 8'd1;
    last = -1;
    done = 0;
    for (int c = 0; c < 80 && !done; c++) begin
      if (c < 2) begin
        code     = C_UP0;
        new_code = 1'b1;
      end else begin
        new_code = 1'b0;
      end
      @(negedge clk);
      cur     = level_out[7:0];
      exp_tgt = (c == 0) ? 8'd6 : 8'd11;
      if (cur != prev) begin
        vectors++;
        if (cur !== prev + 8'd1) begin
          miscompares++;
          $display("FAIL fade_step c%0d: got %0d expected %0d", c, cur, prev + 8'd1);
        end
        if (last >= 0) begin
          vectors++;
          if (c - last != 4) begin
            miscompares++;
            $display("FAIL fade_spacing c%0d: got %0d expected 4", c, c - last);
          end
        end
        last = c;
        prev = cur;
      end
      vectors++;
      if (busy_out !== (cur != exp_tgt) || target_out[7:0] !== exp_tgt) begin
        miscompares++;
        $display("FAIL fade_busy c%0d: got busy=%b tgt=%0d expected busy=%b tgt=%0d",
                 c, busy_out, target_out[7:0], cur != exp_tgt, exp_tgt);
      end
      if (cur == 8'd11) done = 1;
    end
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL fade_timeout: got level %0d expected 11", level_out[7:0]);
    end
  endtask

  task automatic test_ramp_down_and_reset();
    logic [7:0] prev, cur;
    bit done;
    apply_reset();
    send(C_MODE);
    send(C_UP0);
    send(C_UP0);
    repeat (10) @(negedge clk);
    send(C_ALL_OFF);
    vectors++;
    if (target_out !== 24'h000000) begin
      miscompares++;
      $display("FAIL alloff_target: got %h expected 000000", target_out);
    end
    prev = level_out[7:0];
    done = 0;
    for (int c = 0; c < 80 && !done; c++) begin
      @(negedge clk);
      cur = level_out[7:0];
      if (cur != prev) begin
        vectors++;
        if (cur !== prev - 8'd1) begin
          miscompares++;
          $display("FAIL down_step c%0d: got %0d expected %0d", c, cur, prev - 8'd1);
        end
        prev = cur;
      end
      vectors++;
      if (busy_out !== (level_out != 24'h0)) begin
        miscompares++;
        $display("FAIL down_busy c%0d: got %b expected %b", c, busy_out, level_out != 24'h0);
      end
      if (level_out == 24'h0) done = 1;
    end
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL down_timeout: got %h expected 000000", level_out);
    end
    send(C_UP0);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if (level_out !== 24'h010101 || target_out !== 24'h010101) begin
      miscompares++;
      $display("FAIL midramp_reset: got lvl=%h tgt=%h expected 010101", level_out, target_out);
    end
    vectors++;
    if (fade_mode_out !== 1'b0 || busy_out !== 1'b0) begin
      miscompares++;
      $display("FAIL midramp_reset_mode: got mode=%b busy=%b expected 0 0", fade_mode_out, busy_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_tick_collision();
    logic [7:0] prev, lvl;
    bit seen;
    apply_reset();
    send(C_MODE);
    send(C_UP0);
    send(C_UP0);
    seen = 0;
    prev = level_out[7:0];
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (level_out[7:0] != prev) seen = 1;
      else prev = level_out[7:0];
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL coll_tick_timeout: got level %0d expected a step", level_out[7:0]);
    end
    lvl = level_out[7:0];
    repeat (3) @(negedge clk);
    send(C_ALL_OFF);
    vectors++;
    if (level_out[7:0] !== lvl + 8'd1 || target_out[7:0] !== 8'd0) begin
      miscompares++;
      $display("FAIL coll_old_target: got lvl=%0d tgt=%0d expected lvl=%0d tgt=0",
               level_out[7:0], target_out[7:0], lvl + 8'd1);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (level_out[7:0] !== lvl + 8'd1) begin
      miscompares++;
      $display("FAIL coll_hold: got %0d expected %0d", level_out[7:0], lvl + 8'd1);
    end
    @(negedge clk);
    vectors++;
    if (level_out[7:0] !== lvl) begin
      miscompares++;
      $display("FAIL coll_new_target: got %0d expected %0d", level_out[7:0], lvl);
    end
    send(C_MODE);
    vectors++;
    if (fade_mode_out !== 1'b0 || level_out !== 24'h0 || busy_out !== 1'b0) begin
      miscompares++;
      $display("FAIL fade_to_snap: got mode=%b lvl=%h busy=%b expected 0 000000 0",
               fade_mode_out, level_out, busy_out);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_coarse_saturate();
    test_fine_floor();
    test_errors();
    test_back_to_back();
    test_fade_ramp();
    test_ramp_down_and_reset();
    test_tick_collision();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ir_level_ctrl.md
Name: ir_level_ctrl

Overview:
- Parametrised controller that turns decoded IR remote codes into per-channel intensity levels for PWM channels (e.g. RGB LED drive).
- Sits between the IR decoder (32-bit code plus one-cycle new-code strobe) and an array of PWM generators.
- Replaces a hard-coded code table with address/command decoding and a command-complement integrity check.
- Adds saturating arithmetic, broadcast commands, error reporting and an optional fade (ramp) mode.

Parameters:
- NUM_CH, 3, number of level channels (1..16).
- WIDTH, 8, bits per level.
- COARSE_STEP, 5, coarse increment/decrement (< 2^WIDTH).
- FINE_STEP, 1, fine increment/decrement.
- RESET_LEVEL, 1, level and target value after reset or RESTORE.
- ADDR, 16'h57E3, required value of code_in[31:16].
- CMD_BASE, 8'h10, first per-channel command byte. Range CMD_BASE..CMD_BASE+4*NUM_CH-1 must not overlap the special commands.
- CMD_ALL_OFF, 8'h40, sets all targets to 0.
- CMD_RESTORE, 8'h41, sets all targets to RESET_LEVEL.
- CMD_MODE, 8'h42, toggles snap/fade mode.
- RAMP_DIV, 100000, clock cycles per fade step (>= 1).

Ports:
- clk_in  in  1  system clock
- rst_n_in  in  1  asynchronous active-low reset
- code_in  in  32  decoded IR code
- new_code_in  in  1  one-cycle strobe; code_in is valid in that cycle
- level_out  out  NUM_CH*WIDTH  packed levels; channel k at [k*WIDTH +: WIDTH]
- target_out  out  NUM_CH*WIDTH  packed target levels
- fade_mode_out  out  1  0 = snap, 1 = fade
- busy_out  out  1  high while any level differs from its target
- cmd_ok_out  out  1  one-cycle pulse: accepted command
- err_out  out  1  one-cycle pulse: rejected code
- err_code_out  out  2  code of last rejection; held until next rejection

Behaviour:
- Reset (async assert, sync release): all targets and levels = RESET_LEVEL; fade_mode_out=0; prescaler=0; cmd_ok_out=err_out=0; err_code_out=0.
- Decode happens only in a cycle with new_code_in=1. Field split: cmd = code_in[15:8], inv = code_in[7:0].
- Rejection checks, priority order:
  - code_in[31:16] != ADDR → err_code 1
  - inv != ~cmd → err_code 2
  - cmd is neither a channel command nor a special command → err_code 3
- A rejected code changes no state except err_out (pulse) and err_code_out.
- Channel commands, idx = cmd - CMD_BASE: ch = idx/4, op = idx%4.
  - op 0: target += COARSE_STEP
  - op 1: target -= COARSE_STEP
  - op 2: target += FINE_STEP
  - op 3: target -= FINE_STEP
- Arithmetic is computed WIDTH+1 bits wide and saturates: result > 2^WIDTH-1 → 2^WIDTH-1; result < 0 → 0. No wrap-around. A saturated command still counts as accepted (cmd_ok_out pulses).
- Special commands:
  - ALL_OFF: every target = 0.
  - RESTORE: every target = RESET_LEVEL.
  - MODE: fade_mode toggles.
- Latency: strobe in cycle N → target_out, cmd_ok_out/err_out and fade_mode_out update at edge N+1.
- Snap mode: level_out tracks target every cycle, so a level updates at N+1 (same edge as target) and busy_out=0.
- Fade mode:
  - The prescaler counts 0..RAMP_DIV-1 and wraps; it is free-running in both modes.
  - At the wrap tick, each channel whose level != target moves 1 LSB toward its target.
  - busy_out = OR over channels of (level != target), registered.
- Simultaneous tick and command: the tick step uses the pre-command target. The new target takes effect from the next tick.
- Mode switches:
  - Fade→snap: levels jump to targets at the next edge.
  - Snap→fade: no level change (levels already equal targets).
- Back-to-back strobes in consecutive cycles are each processed; no input buffering is required.
- Reset asserted mid-ramp aborts the ramp immediately; all state returns to reset values.

Test Plan:
- Reset, then 32'h57E310EF ×51 (snap) → ch0 level 1,6,…,251,255; last step saturates; cmd_ok_out pulses 51 times.
- Reset, then 32'h57E317E8 ×2 (ch1 fine down) → ch1 level 0, then stays 0; cmd_ok_out pulses both times; err_out stays 0.
- 32'h12E310EF → err_out pulse, err_code_out=1, no level change. 32'h57E310EE → err_code_out=2. 32'h57E37F80 → err_code_out=3.
- RAMP_DIV=4: 32'h57E342BD (fade on), then 32'h57E310EF ×2 → ch0 target 11; level steps +1 every 4 cycles from 1 to 11; busy_out high until level=11.
- Mid-ramp in the previous scenario, send 32'h57E340BF → all targets 0; ch0 ramps down from its current value. Assert rst_n_in low mid-ramp → level_out immediately all RESET_LEVEL, fade_mode_out=0.
- Strobe arriving on the same cycle as a prescaler tick → the step follows the old target; the next tick follows the new target.
